// File: rtl/fetch_exec_if.sv
// fetch_exec_if: ROM fetch bus between the fetch/execute controller (master)
// and the instruction ROM (slave). The ROM returns instr_in one cycle after
// it samples rom_addr with rom_enable high.
interface fetch_exec_if #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned INSTR_W = 25
);
  logic [ADDR_W-1:0]  rom_addr;
  logic               rom_enable;
  logic [INSTR_W-1:0] instr_in;

  modport master (output rom_addr, output rom_enable, input instr_in);
  modport slave  (input rom_addr, input rom_enable, output instr_in);
endinterface

// File: rtl/fetch_exec.sv
// fetch_exec: fetch/decode/execute controller sitting behind the instruction ROM.
// Runs the program from address 0 up to PROG_LEN-1 or a halt opcode, three cycles
// per instruction, on an 8 x DATA_W register file.
// Optional: define FETCH_EXEC_FLAGS_EN to add zero/carry flag outputs.
module fetch_exec #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned PROG_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  fetch_exec_if.master      rom,
  input  logic              i_start,
  output logic              o_running,
  output logic              o_halted,
  output logic              o_retired,
  input  logic [2:0]        i_dbg_sel,
  output logic [DATA_W-1:0] o_dbg_data,
`ifdef FETCH_EXEC_FLAGS_EN
  output logic              o_flag_z,
  output logic              o_flag_c,
`endif
  output logic [DATA_W-1:0] o_r7_out
);

  localparam int unsigned INSTR_W = DATA_W + 9;
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  localparam logic [2:0] OpLoad = 3'b000;
  localparam logic [2:0] OpMov  = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpXor  = 3'b011;
  localparam logic [2:0] OpHalt = 3'b111;

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StDone} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_regs [8];
  logic                r_rom_en;
  logic                r_running;
  logic                r_halted;
  logic                r_retired;

  logic [2:0]          w_op;
  logic [2:0]          w_rd;
  logic [2:0]          w_rs;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_rd_val;
  logic [DATA_W-1:0]   w_rs_val;
  logic [DATA_W-1:0]   w_sum;
  logic [DATA_W-1:0]   w_xor;

  assign w_op     = r_ir[INSTR_W-1 -: 3];
  assign w_rd     = r_ir[INSTR_W-4 -: 3];
  assign w_rs     = r_ir[INSTR_W-7 -: 3];
  assign w_imm    = r_ir[DATA_W-1:0];
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];
  assign w_xor    = w_rd_val ^ w_rs_val;

`ifdef FETCH_EXEC_FLAGS_EN
  logic [DATA_W:0] w_sum_ext;
  logic            r_flag_z;
  logic            r_flag_c;

  assign w_sum_ext = {1'b0, w_rd_val} + {1'b0, w_rs_val};
  assign w_sum     = w_sum_ext[DATA_W-1:0];
  assign o_flag_z  = r_flag_z;
  assign o_flag_c  = r_flag_c;

  // Flags update only on add/xor write-back; start leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else if (r_state == StExec) begin
      if (w_op == OpAdd) begin
        r_flag_c <= w_sum_ext[DATA_W];
        r_flag_z <= (w_sum == '0);
      end else if (w_op == OpXor) begin
        r_flag_c <= 1'b0;
        r_flag_z <= (w_xor == '0);
      end
    end
  end
`else
  assign w_sum = w_rd_val + w_rs_val;
`endif

  assign rom.rom_addr   = r_pc;
  assign rom.rom_enable = r_rom_en;
  assign o_running      = r_running;
  assign o_halted       = r_halted;
  assign o_retired      = r_retired;
  assign o_dbg_data     = r_regs[i_dbg_sel];
  assign o_r7_out       = r_regs[7];

  // Sequencer FSM with registered status outputs and register-file write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pc      <= '0;
      r_ir      <= '0;
      r_rom_en  <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
      r_retired <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_state   <= StFetch;
            r_pc      <= '0;
            r_rom_en  <= 1'b1;
            r_running <= 1'b1;
            r_halted  <= 1'b0;
          end
        end
        StFetch: begin
          r_state  <= StDecode;
          r_rom_en <= 1'b0;
        end
        StDecode: begin
          r_ir      <= rom.instr_in;
          r_state   <= StExec;
          r_retired <= 1'b1;
        end
        StExec: begin
          r_retired <= 1'b0;
          case (w_op)
            OpLoad:  r_regs[w_rd] <= w_imm;
            OpMov:   r_regs[w_rd] <= w_rs_val;
            OpAdd:   r_regs[w_rd] <= w_sum;
            OpXor:   r_regs[w_rd] <= w_xor;
            default: ;
          endcase
          // pc parks on the last executed address once the program ends.
          if (w_op == OpHalt || r_pc == LAST_PC) begin
            r_state   <= StDone;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
          end else begin
            r_state  <= StFetch;
            r_pc     <= r_pc + ADDR_W'(1);
            r_rom_en <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_exec.sv
// tb_fetch_exec: randomized and directed checks of fetch_exec against a
// program-level reference model. Honours FETCH_EXEC_FLAGS_EN.
`timescale 1ns/1ps
module tb_fetch_exec;
  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int PL   = 8;
  localparam int MAXK = 120;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic [2:0]    dbg_sel = 3'd0;
  logic          running, halted, retired;
  logic [DW-1:0] dbg_data, r7_out;
`ifdef FETCH_EXEC_FLAGS_EN
  logic          flag_z, flag_c;
`endif

  fetch_exec_if #(.ADDR_W(AW), .INSTR_W(25)) bus ();

  fetch_exec #(.DATA_W(DW), .ADDR_W(AW), .PROG_LEN(PL)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom        (bus),
    .i_start    (i_start),
    .o_running  (running),
    .o_halted   (halted),
    .o_retired  (retired),
    .i_dbg_sel  (dbg_sel),
    .o_dbg_data (dbg_data),
`ifdef FETCH_EXEC_FLAGS_EN
    .o_flag_z   (flag_z),
    .o_flag_c   (flag_c),
`endif
    .o_r7_out   (r7_out)
  );

  always #10 clk = ~clk;

  logic [24:0] prog [PL];

  // Registered-read ROM behind the fetch bus.
  always @(posedge clk) begin
    if (bus.rom_enable) bus.instr_in <= prog[bus.rom_addr];
  end

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [DW-1:0] m_regs [8];
  bit            m_z, m_c;

  // Per-run observations, indexed by cycles after start was sampled.
  bit          obs_ret  [MAXK];
  bit          obs_en   [MAXK];
  bit          obs_run  [MAXK];
  logic [AW-1:0] obs_addr [MAXK];
  int          obs_halt_k, obs_n_ret, obs_max_addr;

  function automatic logic [24:0] enc(input int op, input int rd, input int rs, input int imm);
    enc = {3'(op), 3'(rd), 3'(rs), 16'(imm)};
  endfunction

  task automatic load_std();
    prog[0] = enc(0, 2, 0, 1);
    prog[1] = enc(0, 1, 0, 1);
    prog[2] = enc(2, 2, 1, 0);
    prog[3] = enc(3, 2, 1, 0);
    prog[4] = enc(1, 7, 1, 0);
    for (int a = 5; a < PL; a++) prog[a] = '0;
  endtask

  // Program-level model: walks the ROM image, returns instructions executed.
  task automatic model_run(output int n_exec, output int last_addr);
    bit stop;
    logic [2:0] op, rd, rs;
    int x, y, s;
    stop = 0; n_exec = 0; last_addr = 0;
    for (int a = 0; a < PL; a++) begin
      if (!stop) begin
        op = prog[a][24:22]; rd = prog[a][21:19]; rs = prog[a][18:16];
        n_exec++; last_addr = a;
        x = int'(m_regs[rd]); y = int'(m_regs[rs]);
        case (op)
          3'd0: m_regs[rd] = prog[a][15:0];
          3'd1: m_regs[rd] = m_regs[rs];
          3'd2: begin
            s = x + y;
            m_c = (s > 65535);
            m_regs[rd] = 16'(s % 65536);
            m_z = ((s % 65536) == 0);
          end
          3'd3: begin
            s = x ^ y;
            m_regs[rd] = 16'(s);
            m_z = (s == 0);
            m_c = 0;
          end
          3'd7: stop = 1;
          default: ;
        endcase
      end
    end
  endtask

  // Pulse start and record outputs every cycle until halted (bounded).
  task automatic run_prog(input bit hold_start);
    for (int i = 0; i < MAXK; i++) begin
      obs_ret[i] = 0; obs_en[i] = 0; obs_run[i] = 0; obs_addr[i] = '0;
    end
    obs_halt_k = -1; obs_n_ret = 0; obs_max_addr = 0;
    @(negedge clk); i_start = 1'b1;
    for (int k = 1; k < MAXK; k++) begin
      @(negedge clk);
      i_start     = hold_start;
      obs_ret[k]  = retired;
      obs_en[k]   = bus.rom_enable;
      obs_run[k]  = running;
      obs_addr[k] = bus.rom_addr;
      if (retired) obs_n_ret++;
      if (int'(bus.rom_addr) > obs_max_addr) obs_max_addr = int'(bus.rom_addr);
      if (halted) begin
        obs_halt_k = k;
        i_start = 1'b0;
        break;
      end
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 8; r++) m_regs[r] = '0;
    m_z = 0; m_c = 0;
    @(negedge clk);
    checks++;
    if ({bus.rom_addr, bus.rom_enable, running, halted, retired} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d en=%b run=%b halt=%b ret=%b want all 0",
               bus.rom_addr, bus.rom_enable, running, halted, retired);
    end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk); dbg_sel = 3'(r); #1;
      checks++;
      if (dbg_data !== 16'h0) begin
        errors++; $display("FAIL reset_reg r%0d: got %h want 0000", r, dbg_data);
      end
    end
    checks++;
    if (r7_out !== 16'h0) begin errors++; $display("FAIL reset_r7: got %h want 0000", r7_out); end
`ifdef FETCH_EXEC_FLAGS_EN
    checks++;
    if ({flag_z, flag_c} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got z=%b c=%b want 0 0", flag_z, flag_c);
    end
`endif
  endtask

  task automatic test_standard();
    int n, last, bad;
    load_std();
    model_run(n, last);
    run_prog(1'b0);
    checks++;
    if (!(obs_en[1] === 1'b1 && obs_addr[1] === 3'd0 && obs_en[2] === 1'b0)) begin
      errors++; $display("FAIL std_first_fetch: got en1=%b addr1=%0d en2=%b want 1 0 0",
                         obs_en[1], obs_addr[1], obs_en[2]);
    end
    checks++;
    if (obs_addr[4] !== 3'd1) begin
      errors++; $display("FAIL std_second_fetch: got addr=%0d want 1", obs_addr[4]);
    end
    bad = 0;
    for (int k = 1; k <= 25; k++) if (obs_ret[k] !== (k % 3 == 0 && k <= 24)) bad++;
    checks++;
    if (bad != 0 || obs_n_ret != 8) begin
      errors++; $display("FAIL std_retire_pattern: got %0d pulses (%0d misplaced) want 8 every 3",
                         obs_n_ret, bad);
    end
    checks++;
    if (obs_halt_k != 25) begin
      errors++; $display("FAIL std_halt_time: got %0d want 25", obs_halt_k);
    end
    checks++;
    if (!(obs_run[1] === 1'b1 && obs_run[24] === 1'b1 && running === 1'b0)) begin
      errors++; $display("FAIL std_running: got %b %b %b want 1 1 0", obs_run[1], obs_run[24], running);
    end
    @(negedge clk); dbg_sel = 3'd2; #1;
    checks++;
    if (dbg_data !== 16'h0003) begin errors++; $display("FAIL std_r2: got %h want 0003", dbg_data); end
    @(negedge clk); dbg_sel = 3'd1; #1;
    checks++;
    if (dbg_data !== 16'h0001) begin errors++; $display("FAIL std_r1: got %h want 0001", dbg_data); end
    @(negedge clk); dbg_sel = 3'd0; #1;
    checks++;
    if (dbg_data !== 16'h0000) begin errors++; $display("FAIL std_r0: got %h want 0000", dbg_data); end
    checks++;
    if (r7_out !== 16'h0001) begin errors++; $display("FAIL std_r7: got %h want 0001", r7_out); end
  endtask

  task automatic test_halt();
    int n, last;
    prog[0] = enc(0, 3, 0, 16'h1234);
    prog[1] = enc(0, 4, 0, 16'h5678);
    prog[2] = enc(7, 0, 0, 0);
    prog[3] = enc(0, 5, 0, 16'hAAAA);
    prog[4] = enc(2, 3, 4, 0);
    prog[5] = enc(0, 0, 0, 16'hBEEF);
    prog[6] = enc(1, 7, 3, 0);
    prog[7] = enc(3, 6, 3, 0);
    model_run(n, last);
    run_prog(1'b0);
    checks++;
    if (obs_n_ret != 3 || obs_halt_k != 10) begin
      errors++; $display("FAIL halt_count: got ret=%0d halt_k=%0d want 3 10", obs_n_ret, obs_halt_k);
    end
    checks++;
    if (obs_max_addr != 2) begin
      errors++; $display("FAIL halt_max_addr: got %0d want 2", obs_max_addr);
    end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk); dbg_sel = 3'(r); #1;
      checks++;
      if (dbg_data !== m_regs[r]) begin
        errors++; $display("FAIL halt_reg r%0d: got %h want %h", r, dbg_data, m_regs[r]);
      end
    end
  endtask

  task automatic test_overflow();
    int n, last;
    prog[0] = enc(0, 1, 0, 16'hFFFF);
    prog[1] = enc(0, 2, 0, 16'h0001);
    prog[2] = enc(2, 1, 2, 0);
    prog[3] = enc(7, 0, 0, 0);
    for (int a = 4; a < PL; a++) prog[a] = enc(0, 5, 0, 16'h5555);
    model_run(n, last);
    run_prog(1'b0);
    checks++;
    if (obs_halt_k != 3 * n + 1) begin
      errors++; $display("FAIL ovf_halt_time: got %0d want %0d", obs_halt_k, 3 * n + 1);
    end
    @(negedge clk); dbg_sel = 3'd1; #1;
    checks++;
    if (dbg_data !== 16'h0000) begin errors++; $display("FAIL ovf_r1: got %h want 0000", dbg_data); end
`ifdef FETCH_EXEC_FLAGS_EN
    checks++;
    if ({flag_z, flag_c} !== 2'b11) begin
      errors++; $display("FAIL ovf_flags: got z=%b c=%b want 1 1", flag_z, flag_c);
    end
`endif
  endtask

  task automatic test_restart();
    int n, last;
    load_std();
    model_run(n, last);
    run_prog(1'b0);
    checks++;
    if (obs_halt_k != 25 || obs_addr[1] !== 3'd0) begin
      errors++; $display("FAIL restart_timing: got halt_k=%0d addr1=%0d want 25 0",
                         obs_halt_k, obs_addr[1]);
    end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk); dbg_sel = 3'(r); #1;
      checks++;
      if (dbg_data !== m_regs[r]) begin
        errors++; $display("FAIL restart_reg r%0d: got %h want %h", r, dbg_data, m_regs[r]);
      end
    end
    @(negedge clk); dbg_sel = 3'd2; #1;
    checks++;
    if (dbg_data !== 16'h0003) begin errors++; $display("FAIL restart_r2: got %h want 0003", dbg_data); end
  endtask

  task automatic test_start_ignored();
    int n, last;
    load_std();
    model_run(n, last);
    run_prog(1'b1);
    checks++;
    if (obs_addr[4] !== 3'd1 || obs_addr[7] !== 3'd2) begin
      errors++; $display("FAIL ignore_start_pc: got addr4=%0d addr7=%0d want 1 2",
                         obs_addr[4], obs_addr[7]);
    end
    checks++;
    if (obs_halt_k != 25 || obs_n_ret != 8) begin
      errors++; $display("FAIL ignore_start_len: got halt_k=%0d ret=%0d want 25 8",
                         obs_halt_k, obs_n_ret);
    end
  endtask

  task automatic test_random();
    int n, last;
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < PL; a++)
        prog[a] = enc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 65535));
      model_run(n, last);
      run_prog(1'b0);
      checks++;
      if (obs_n_ret != n || obs_halt_k != 3 * n + 1 || obs_max_addr != last) begin
        errors++; $display("FAIL rand%0d_seq: got ret=%0d halt_k=%0d maxaddr=%0d want %0d %0d %0d",
                           it, obs_n_ret, obs_halt_k, obs_max_addr, n, 3 * n + 1, last);
      end
      for (int r = 0; r < 8; r++) begin
        @(negedge clk); dbg_sel = 3'(r); #1;
        checks++;
        if (dbg_data !== m_regs[r]) begin
          errors++; $display("FAIL rand%0d_reg r%0d: got %h want %h", it, r, dbg_data, m_regs[r]);
        end
      end
      checks++;
      if (r7_out !== m_regs[7]) begin
        errors++; $display("FAIL rand%0d_r7: got %h want %h", it, r7_out, m_regs[7]);
      end
`ifdef FETCH_EXEC_FLAGS_EN
      checks++;
      if ({flag_z, flag_c} !== {m_z, m_c}) begin
        errors++; $display("FAIL rand%0d_flags: got z=%b c=%b want %b %b", it, flag_z, flag_c, m_z, m_c);
      end
`endif
    end
  endtask

  task automatic test_rst_decode();
    int n, last;
    load_std();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;   // FETCH
    @(negedge clk); rst = 1'b1;       // DECODE
    @(negedge clk);
    checks++;
    if ({bus.rom_addr, bus.rom_enable, running, halted, retired} !== '0) begin
      errors++;
      $display("FAIL rst_decode_outputs: got addr=%0d en=%b run=%b halt=%b ret=%b want all 0",
               bus.rom_addr, bus.rom_enable, running, halted, retired);
    end
    rst = 1'b0;
    for (int r = 0; r < 8; r++) m_regs[r] = '0;
    m_z = 0; m_c = 0;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk); dbg_sel = 3'(r); #1;
      checks++;
      if (dbg_data !== 16'h0) begin
        errors++; $display("FAIL rst_decode_reg r%0d: got %h want 0000", r, dbg_data);
      end
    end
    checks++;
    if (running !== 1'b0 || bus.rom_enable !== 1'b0) begin
      errors++; $display("FAIL rst_decode_idle: got run=%b en=%b want 0 0", running, bus.rom_enable);
    end
`ifdef FETCH_EXEC_FLAGS_EN
    checks++;
    if ({flag_z, flag_c} !== 2'b00) begin
      errors++; $display("FAIL rst_decode_flags: got z=%b c=%b want 0 0", flag_z, flag_c);
    end
`endif
    model_run(n, last);
    run_prog(1'b0);
    checks++;
    if (obs_halt_k != 25 || r7_out !== m_regs[7]) begin
      errors++; $display("FAIL rst_decode_rerun: got halt_k=%0d r7=%h want 25 %h",
                         obs_halt_k, r7_out, m_regs[7]);
    end
  endtask

  initial begin
    test_reset();
    test_standard();
    test_halt();
    test_overflow();
    test_restart();
    test_start_ignored();
    test_random();
    test_rst_decode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_exec.md
Name: fetch_exec

Overview:
- Fetch/execute controller directly downstream of the instruction ROM.
- Drives the ROM address and enable, and captures the 25-bit instruction word that the ROM returns one cycle later.
- Decodes the word and executes it on an internal 8 x 16-bit register file: load, mov, add, xor, nop, halt.
- Sequences the program from address 0 to the last address, or until a halt opcode, then stops and reports done.

Parameters:
- DATA_W, 16, register and immediate width.
- ADDR_W, 3, ROM address width.
- PROG_LEN, 8, number of ROM words executed before an automatic halt (1..2**ADDR_W).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin execution from address 0.
- instr_in  in  25  ROM data_out: [24:22] op, [21:19] rd, [18:16] rs, [15:0] imm.
- rom_addr  out  ADDR_W  ROM address (= pc).
- rom_enable  out  1  high while a fetch is outstanding.
- running  out  1  high from the start acceptance through the final execute cycle.
- halted  out  1  high after program end until the next start or rst.
- retired  out  1  one-cycle pulse in each EXEC cycle.
- dbg_sel  in  3  register-file read select.
- dbg_data  out  DATA_W  combinational read of regfile[dbg_sel].
- r7_out  out  DATA_W  continuous copy of r7.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, pc=0, IR=0, all regs=0, rom_addr=0, rom_enable=0, running=0, halted=0, retired=0. rst mid-instruction aborts with no register write.
- States: IDLE, FETCH, DECODE, EXEC, DONE.
- IDLE: start=1 -> FETCH, pc=0.
- FETCH (1 cycle): rom_addr=pc, rom_enable=1. The ROM registers mem[pc] at the closing edge. -> DECODE.
- DECODE (1 cycle): rom_addr still =pc, rom_enable=0. IR<=instr_in at the closing edge. -> EXEC.
- EXEC (1 cycle): retired=1 and write-back at the closing edge:
  - op 000 load: rd<=imm.
  - op 001 mov: rd<=rs.
  - op 010 add: rd<=rd+rs, mod 2**DATA_W, carry discarded.
  - op 011 xor: rd<=rd^rs.
  - op 100-110: nop.
  - op 111: halt, no write.
- Register reads in EXEC use pre-write values; rd==rs is legal (add r1 r1 doubles).
- Next state from EXEC:
  - op 111, or pc==PROG_LEN-1 -> DONE.
  - otherwise pc<=pc+1 -> FETCH.
- pc never wraps past PROG_LEN-1.
- Latency: 3 cycles per instruction; the first FETCH is the cycle after start is sampled.
- DONE: halted=1, running=0, registers retained. start=1 -> FETCH with pc=0 and halted cleared; registers are not cleared.
- start while running is ignored.
- r0 is an ordinary writable register.
- dbg_data and r7_out reflect a write in the cycle after the EXEC edge.

Optional Feature:
- Macro FETCH_EXEC_FLAGS_EN.
- Defined:
  - Adds outputs flag_z (1 bit) and flag_c (1 bit), both reset to 0.
  - add sets flag_c to the carry-out and flag_z to (result==0).
  - xor sets flag_z to (result==0) and flag_c to 0.
  - load, mov, nop and halt leave both flags unchanged.
  - start does not clear the flags.
- Undefined: ports absent, no flag logic, otherwise identical.

Test Plan:
- Standard program (load r2 1; load r1 1; add r2 r1; xor r2 r1; mov r7 r1; then 3 x all-zero words):
  - start -> retired pulses 8 times, 3 cycles apart.
  - halted rises 24 cycles after the first FETCH.
  - final r2=3, r1=1, r7=1, r0=0.
- Latency check: start at cycle 0 -> rom_enable=1 with rom_addr=0 in cycle 1, rom_addr=1 in cycle 4, first retired in cycle 3.
- Halt opcode at address 2 -> halted after 3 retirements, rom_addr never exceeds 2, regs beyond the first two loads unchanged.
- Overflow: load r1 0xFFFF; load r2 0x0001; add r1 r2 -> r1=0x0000; with FETCH_EXEC_FLAGS_EN, flag_c=1 and flag_z=1.
- rst asserted during a DECODE cycle -> next cycle all outputs and regs at reset values. start while running is ignored (no pc change).
- Restart: start in DONE -> re-executes from pc=0 with registers retained. The standard program ends with r2=0x0003 again, because the loads re-initialise r1 and r2.
